// File: rtl/vdma_burst_arbiter_pkg.sv
// Shared types and helpers for the VDMA burst arbiter and its round-robin picker.
package vdma_arb_pkg;

    localparam int MAX_CH  = 8;
    localparam int MAX_CHW = 3;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT_DONE,
        RELEASE
    } arb_state_e;

    typedef struct packed {
        logic               found;
        logic [MAX_CHW-1:0] idx;
    } rr_result_t;

    // Channel index width for a given channel count; never narrower than one bit.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requesting channel strictly after ptr, wrapping at num_ch.
    function automatic rr_result_t rr_first(input logic [MAX_CH-1:0]  req,
                                            input logic [MAX_CHW-1:0] ptr,
                                            input int                 num_ch);
        rr_result_t         res;
        logic [MAX_CHW-1:0] pos;
        res = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            pos = MAX_CHW'((int'(ptr) + k) % num_ch);
            if (k <= num_ch && !res.found && req[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vdma_burst_arbiter_if.sv
// Command/completion bus between the arbiter and the shared AXI burst engine.
interface vdma_burst_arbiter_if
    import vdma_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int LSIZE  = 9
);
    localparam int CHW = chw_of(NUM_CH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LSIZE-1:0] cmd_len;
    logic             cmd_tail;
    logic [CHW-1:0]   cmd_ch;
    logic             eng_done;

    modport master (
        output cmd_valid, cmd_len, cmd_tail, cmd_ch,
        input  cmd_ready, eng_done
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_tail, cmd_ch,
        output cmd_ready, eng_done
    );
endinterface

// File: rtl/vdma_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: request vector + last-served pointer -> one-hot grant and index.
module rr_pick
    import vdma_arb_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CHW    = chw_of(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CHW-1:0]    ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CHW-1:0]    idx,
    output logic              found
);
    rr_result_t pick;

    // Search from the channel after the pointer so the last-served channel goes last.
    always_comb begin
        pick = rr_first(MAX_CH'(req), MAX_CHW'(ptr), NUM_CH);
    end

    assign idx   = CHW'(pick.idx);
    assign found = pick.found;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
        assign grant[gi] = pick.found && (pick.idx == MAX_CHW'(gi));
    end
endmodule

// File: rtl/vdma_burst_arbiter.sv
// Round-robin arbiter sharing one AXI burst engine between NUM_CH VDMA requesters.
module vdma_burst_arbiter
    import vdma_arb_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int LSIZE  = 9,
    localparam int CHW    = chw_of(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_burst,
    input  logic [NUM_CH-1:0]       req_tail,
    input  logic [NUM_CH*LSIZE-1:0] req_len,
    input  logic [NUM_CH-1:0]       ch_fsync,
    output logic [NUM_CH-1:0]       ch_resp,
    output logic [NUM_CH-1:0]       ch_done,
    vdma_burst_arbiter_if.master    eng,
    output logic                    busy
);
    arb_state_e        state_reg, state_next;
    logic [CHW-1:0]    ptr_reg, ptr_next;
    logic              abort_reg, abort_next;
    logic [NUM_CH-1:0] winner_oh_reg, winner_oh_next;
    logic              cmd_valid_reg, cmd_valid_next;
    logic [LSIZE-1:0]  cmd_len_reg, cmd_len_next;
    logic              cmd_tail_reg, cmd_tail_next;
    logic [CHW-1:0]    cmd_ch_reg, cmd_ch_next;
    logic [NUM_CH-1:0] ch_resp_reg, ch_resp_next;
    logic [NUM_CH-1:0] ch_done_reg, ch_done_next;
    logic              busy_reg;

    logic [NUM_CH-1:0] req_any;
    logic [NUM_CH-1:0] pick_grant;
    logic [CHW-1:0]    pick_idx;
    logic              pick_found;
    logic              abort_now;

    assign req_any = req_burst | req_tail;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (req_any),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state and registered-output logic; the engine handshake is never broken by an abort.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        abort_next     = abort_reg;
        winner_oh_next = winner_oh_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_len_next   = cmd_len_reg;
        cmd_tail_next  = cmd_tail_reg;
        cmd_ch_next    = cmd_ch_reg;
        ch_resp_next   = '0;
        ch_done_next   = '0;
        abort_now      = abort_reg | (|(ch_fsync & winner_oh_reg));

        case (state_reg)
            IDLE: begin
                if (|req_any) state_next = GRANT;
            end
            GRANT: begin
                if (pick_found) begin
                    winner_oh_next = pick_grant;
                    cmd_ch_next    = pick_idx;
                    cmd_len_next   = req_len[int'(pick_idx)*LSIZE +: LSIZE];
                    cmd_tail_next  = req_tail[pick_idx];
                    cmd_valid_next = 1'b1;
                    abort_next     = |(ch_fsync & pick_grant);
                    state_next     = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                abort_next = abort_now;
                if (eng.cmd_ready) begin
                    cmd_valid_next = 1'b0;
                    if (!abort_now) ch_resp_next = winner_oh_reg;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                abort_next = abort_now;
                if (eng.eng_done) begin
                    if (!abort_now) ch_done_next = winner_oh_reg;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                ptr_next   = cmd_ch_reg;
                abort_next = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset starts the pointer at the last channel so ch0 wins first.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= CHW'(NUM_CH - 1);
            abort_reg     <= 1'b0;
            winner_oh_reg <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_len_reg   <= '0;
            cmd_tail_reg  <= 1'b0;
            cmd_ch_reg    <= '0;
            ch_resp_reg   <= '0;
            ch_done_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            abort_reg     <= abort_next;
            winner_oh_reg <= winner_oh_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_len_reg   <= cmd_len_next;
            cmd_tail_reg  <= cmd_tail_next;
            cmd_ch_reg    <= cmd_ch_next;
            ch_resp_reg   <= ch_resp_next;
            ch_done_reg   <= ch_done_next;
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign eng.cmd_valid = cmd_valid_reg;
    assign eng.cmd_len   = cmd_len_reg;
    assign eng.cmd_tail  = cmd_tail_reg;
    assign eng.cmd_ch    = cmd_ch_reg;
    assign ch_resp       = ch_resp_reg;
    assign ch_done       = ch_done_reg;
    assign busy          = busy_reg;
endmodule
